// File: rtl/otter_pipe_pkg.sv
// Shared OTTER pipeline definitions: fetch FSM states, architectural
// constants and the skid-buffer entry layout. Decode and hazard stages
// import the same package so state/constant encodings stay consistent.
package otter_pipe_pkg;

  // Fetch stage FSM states.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // addi x0,x0,0 -- the canonical bubble.
  localparam logic [31:0] OTTER_NOP      = 32'h0000_0013;
  localparam logic [31:0] OTTER_RESET_PC = 32'h0000_0000;

  // One parked fetch result: the instruction word and the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } skid_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: hazard controls, instruction-memory port and the
// IF/ID fetch register.
//
// Instruction memory handshake: IMEM_REQ acts as "valid" for the read
// request and IMEM_ADDR is held stable while IMEM_REQ && !IMEM_ACK.
// IMEM_ACK is the memory's completion/"ready" and qualifies IMEM_DATA in
// the same cycle; a transfer happens on a clock edge where both IMEM_REQ
// and IMEM_ACK are high. ACK may arrive in the same cycle as REQ (zero wait).
// The request may only be withdrawn after it has been acknowledged.
interface fetch_stage_if;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_DATA;
  logic [31:0] FR_MEM;
  logic [31:0] FR_PC;
  logic [31:0] FR_PC_4;
  logic        FR_VALID;

  // Fetch stage side.
  modport master (
    input  STALL, REDIRECT, REDIRECT_PC, IMEM_ACK, IMEM_DATA,
    output IMEM_REQ, IMEM_ADDR, FR_MEM, FR_PC, FR_PC_4, FR_VALID
  );

  // Environment side: hazard unit, instruction memory and decode stage.
  modport slave (
    output STALL, REDIRECT, REDIRECT_PC, IMEM_ACK, IMEM_DATA,
    input  IMEM_REQ, IMEM_ADDR, FR_MEM, FR_PC, FR_PC_4, FR_VALID
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer that parks a fetch result which arrived
// while decode was stalled. clear (flush) and drain both empty it; clear
// and drain take precedence over load.
module fetch_skid_buf
  import otter_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  skid_entry_t din,
  output skid_entry_t dout,
  output logic        valid
);

  skid_entry_t entry_q;
  logic        valid_q;

  // Entry storage and occupancy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else if (clear || drain) begin
      valid_q <= 1'b0;
    end else if (load) begin
      entry_q <= din;
      valid_q <= 1'b1;
    end
  end

  assign dout  = entry_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// OTTER IF stage: owns the PC, drives the instruction-memory request and
// writes the IF/ID fetch register. Honours STALL and REDIRECT from the
// hazard unit (REDIRECT > STALL > normal); flushed slots become NOP bubbles.
// Optional build macro FETCH_PERF_CNT_EN adds FETCH_COUNT / BUBBLE_COUNT.
module fetch_stage
  import otter_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = OTTER_RESET_PC,
  parameter logic [31:0] NOP_INSTR = OTTER_NOP
) (
  input  logic          REG_CLOCK,
  input  logic          REG_RESET,
  fetch_stage_if.master bus,
  output fetch_state_t  dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   FETCH_COUNT,
  output logic [31:0]   BUBBLE_COUNT
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;

  logic [31:0]  fr_mem_q, fr_pc_q, fr_pc4_q;
  logic         fr_valid_q;

  // Fetch register load controls and payload.
  logic         fr_load_real;
  logic         fr_load_bubble;
  logic [31:0]  fr_instr_d;
  logic [31:0]  fr_pc_d;

  // Skid buffer controls.
  logic         skid_load, skid_drain, skid_clear, skid_valid;
  skid_entry_t  skid_din, skid_dout;

  logic         ack;
  logic         stall;

  assign ack   = bus.IMEM_ACK;
  assign stall = bus.STALL;

  assign skid_din = '{instr: bus.IMEM_DATA, pc: pc_q};

  fetch_skid_buf u_skid (
    .clk   (REG_CLOCK),
    .rst   (REG_RESET),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .din   (skid_din),
    .dout  (skid_dout),
    .valid (skid_valid)
  );

  // Next-state, PC and fetch-register control; redirect outranks stall.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drain_addr_d   = drain_addr_q;
    fr_load_real   = 1'b0;
    fr_load_bubble = 1'b0;
    fr_instr_d     = bus.IMEM_DATA;
    fr_pc_d        = pc_q;
    skid_load      = 1'b0;
    skid_drain     = 1'b0;
    skid_clear     = 1'b0;

    if (bus.REDIRECT) begin
      pc_d           = word_align(bus.REDIRECT_PC);
      fr_load_bubble = 1'b1;
      skid_clear     = 1'b1;
      case (state_q)
        FETCH: begin
          // An unacknowledged request cannot be withdrawn: finish it first.
          if (!ack) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end else begin
            state_d = FETCH;
          end
        end
        DRAIN:   state_d = ack ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (ack && !stall) begin
            fr_load_real = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else if (ack && stall) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else if (!ack && !stall) begin
            fr_load_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall && skid_valid) begin
            fr_load_real = 1'b1;
            fr_instr_d   = skid_dout.instr;
            fr_pc_d      = skid_dout.pc;
            pc_d         = pc_q + 32'd4;
            skid_drain   = 1'b1;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          // Old-path data is dropped; the register keeps showing a bubble.
          if (!stall) fr_load_bubble = 1'b1;
          if (ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM state, PC and drain address registers.
  always_ff @(posedge REG_CLOCK or posedge REG_RESET) begin
    if (REG_RESET) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // IF/ID fetch register; a bubble keeps the previous FR_PC/FR_PC_4.
  always_ff @(posedge REG_CLOCK or posedge REG_RESET) begin
    if (REG_RESET) begin
      fr_mem_q   <= NOP_INSTR;
      fr_pc_q    <= 32'd0;
      fr_pc4_q   <= 32'd0;
      fr_valid_q <= 1'b0;
    end else if (fr_load_bubble) begin
      fr_mem_q   <= NOP_INSTR;
      fr_valid_q <= 1'b0;
    end else if (fr_load_real) begin
      fr_mem_q   <= fr_instr_d;
      fr_pc_q    <= fr_pc_d;
      fr_pc4_q   <= fr_pc_d + 32'd4;
      fr_valid_q <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  // Counts of real loads and bubble loads into the fetch register.
  always_ff @(posedge REG_CLOCK or posedge REG_RESET) begin
    if (REG_RESET) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (fr_load_real)   fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (fr_load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign FETCH_COUNT  = fetch_cnt_q;
  assign BUBBLE_COUNT = bubble_cnt_q;
`endif

  // The request is suppressed while reset is held so it first rises in the
  // cycle after release; HOLD parks the result and issues nothing.
  assign bus.IMEM_REQ  = !REG_RESET && (state_q != HOLD);
  assign bus.IMEM_ADDR = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign bus.FR_MEM   = fr_mem_q;
  assign bus.FR_PC    = fr_pc_q;
  assign bus.FR_PC_4  = fr_pc4_q;
  assign bus.FR_VALID = fr_valid_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a short
// random wait-state run; expected fetch-register contents go through a
// scoreboard queue. Build with +define+FETCH_PERF_CNT_EN to cover counters.
module tb_fetch_stage;
  import otter_pipe_pkg::*;

  localparam int W = 97;  // {FR_VALID, FR_MEM, FR_PC, FR_PC_4}
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk;
  logic         rst;
  logic         ack_en;
  fetch_state_t dbg_state;
  fetch_stage_if bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_pass;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Instruction memory: deterministic word per address, ACK only with REQ.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_5A57;
  endfunction

  assign bus.IMEM_ACK  = ack_en & bus.IMEM_REQ;
  assign bus.IMEM_DATA = bus.IMEM_ACK ? mem_word(bus.IMEM_ADDR) : 32'hDEAD_BEEF;

  fetch_stage dut (
    .REG_CLOCK (clk),
    .REG_RESET (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FETCH_COUNT  (fetch_count),
    .BUBBLE_COUNT (bubble_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] frv(input logic v, input logic [31:0] i, input logic [31:0] p,
                                       input logic [31:0] q);
    return {v, i, p, q};
  endfunction

  // driver: one cycle starting and ending at a falling edge
  task automatic step(input logic st, input logic rd, input logic [31:0] rp, input logic ak,
                      input logic exp_req, input logic [31:0] exp_addr,
                      input fetch_state_t exp_state, input logic [W-1:0] exp_fr);
    logic [W-1:0] want;
    bus.STALL       = st;
    bus.REDIRECT    = rd;
    bus.REDIRECT_PC = rp;
    ack_en          = ak;
    #1;
    check("state", dbg_state, exp_state);
    check("imem_req", bus.IMEM_REQ, exp_req);
    if (exp_req) check("imem_addr", bus.IMEM_ADDR, exp_addr);
    exp_q.push_back(exp_fr);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check("fr", {bus.FR_VALID, bus.FR_MEM, bus.FR_PC, bus.FR_PC_4}, want);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, bus.IMEM_REQ, 1'b0);
    check({tag, "_fr"}, {bus.FR_VALID, bus.FR_MEM, bus.FR_PC, bus.FR_PC_4},
          frv(1'b0, NOP, 32'd0, 32'd0));
    check({tag, "_state"}, dbg_state, FETCH);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_fcnt"}, fetch_count, 32'd0);
    check({tag, "_bcnt"}, bubble_count, 32'd0);
`endif
  endtask

  logic [W-1:0] e_fr;
  logic [31:0]  m_pc;
  logic         ak;

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    rst             = 1'b1;
    ack_en          = 1'b0;
    bus.STALL       = 1'b0;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Zero-wait fetches from reset PC.
    step(0, 0, 0, 1, 1, 32'h0, FETCH, frv(1, mem_word(32'h0), 32'h0, 32'h4));
    step(0, 0, 0, 1, 1, 32'h4, FETCH, frv(1, mem_word(32'h4), 32'h4, 32'h8));
    step(0, 0, 0, 1, 1, 32'h8, FETCH, frv(1, mem_word(32'h8), 32'h8, 32'hC));
`ifdef FETCH_PERF_CNT_EN
    check("fcnt_after3", fetch_count, 32'd3);
    check("bcnt_after3", bubble_count, 32'd0);
`endif

    // Redirect back to 0 with ACK in the same cycle: data dropped.
    step(0, 1, 32'h0, 1, 1, 32'hC, FETCH, frv(0, NOP, 32'h8, 32'hC));

    // Two wait states at PC 0, address held.
    step(0, 0, 0, 0, 1, 32'h0, FETCH, frv(0, NOP, 32'h8, 32'hC));
    step(0, 0, 0, 0, 1, 32'h0, FETCH, frv(0, NOP, 32'h8, 32'hC));
    step(0, 0, 0, 1, 1, 32'h0, FETCH, frv(1, mem_word(32'h0), 32'h0, 32'h4));

    // Stall on the ACK of PC 8: HOLD, then release.
    step(0, 0, 0, 1, 1, 32'h4, FETCH, frv(1, mem_word(32'h4), 32'h4, 32'h8));
    step(1, 0, 0, 1, 1, 32'h8, FETCH, frv(1, mem_word(32'h4), 32'h4, 32'h8));
    step(1, 0, 0, 0, 0, 32'h0, HOLD, frv(1, mem_word(32'h4), 32'h4, 32'h8));
    step(1, 0, 0, 0, 0, 32'h0, HOLD, frv(1, mem_word(32'h4), 32'h4, 32'h8));
    step(0, 0, 0, 0, 0, 32'h0, HOLD, frv(1, mem_word(32'h8), 32'h8, 32'hC));

    // Redirect to 0x103 while request to 0xC pending: DRAIN.
    step(0, 1, 32'h103, 0, 1, 32'hC, FETCH, frv(0, NOP, 32'h8, 32'hC));
    step(0, 0, 0, 0, 1, 32'hC, DRAIN, frv(0, NOP, 32'h8, 32'hC));
    step(0, 0, 0, 1, 1, 32'hC, DRAIN, frv(0, NOP, 32'h8, 32'hC));
    step(0, 0, 0, 1, 1, 32'h100, FETCH, frv(1, mem_word(32'h100), 32'h100, 32'h104));

    // Second redirect while draining overwrites the target.
    step(0, 1, 32'h200, 0, 1, 32'h104, FETCH, frv(0, NOP, 32'h100, 32'h104));
    step(0, 1, 32'h300, 0, 1, 32'h104, DRAIN, frv(0, NOP, 32'h100, 32'h104));
    step(0, 0, 0, 1, 1, 32'h104, DRAIN, frv(0, NOP, 32'h100, 32'h104));
    step(0, 0, 0, 1, 1, 32'h300, FETCH, frv(1, mem_word(32'h300), 32'h300, 32'h304));

    // Redirect + stall together, then PC wrap at the top of memory.
    step(1, 1, 32'hFFFF_FFFE, 1, 1, 32'h304, FETCH, frv(0, NOP, 32'h300, 32'h304));
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFC, FETCH,
         frv(1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0));
    step(0, 0, 0, 1, 1, 32'h0, FETCH, frv(1, mem_word(32'h0), 32'h0, 32'h4));

    // Random wait states, no stall or redirect.
    m_pc = 32'h4;
    e_fr = frv(1, mem_word(32'h0), 32'h0, 32'h4);
    for (int i = 0; i < 16; i++) begin
      ak = 1'($urandom_range(0, 1));
      if (ak) e_fr = frv(1, mem_word(m_pc), m_pc, m_pc + 32'd4);
      else    e_fr = {1'b0, NOP, e_fr[63:0]};
      step(0, 0, 0, ak, 1, m_pc, FETCH, e_fr);
      if (ak) m_pc = m_pc + 32'd4;
    end

    // Enter HOLD, then assert reset asynchronously mid-cycle.
    step(1, 0, 0, 1, 1, m_pc, FETCH, e_fr);
    check("in_hold", dbg_state, HOLD);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 1, 1, 32'h0, FETCH, frv(1, mem_word(32'h0), 32'h0, 32'h4));

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
